pwm_duty_ctrl: RTL and testbench

Duty-cycle controller for the 10-step PWM datapath. It debounces the increment and decrement push-buttons and arbitrates between manual button requests and an autonomous triangular ramp sequencer. It drives the duty value consumed by the PWM comparator. Duty updates are applied only on a PWM period boundary (period_end), so the PWM output never glitches mid-period.

---
 rtl/pwm_duty_ctrl.sv | 158 +++++++++++++++
 tb/tb_pwm_duty_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ctrl.sv
// Duty-cycle controller: debounced inc/dec buttons and a triangular ramp sequencer
// drive the PWM duty value, which only ever changes on a PWM period boundary.
module pwm_duty_ctrl #(
    parameter int DUTY_W       = 4,
    parameter int DUTY_MAX     = 10,
    parameter int DUTY_INIT    = 5,
    parameter int DEB_DIV      = 2,
    parameter int RAMP_DIV     = 4,
    parameter int HOLD_PERIODS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic              period_end,
    input  logic              ramp_start,
    input  logic              ramp_stop,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              at_max,
    output logic              at_min
);
    localparam int DIV_W   = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam int CNT_TOP = (RAMP_DIV > HOLD_PERIODS) ? RAMP_DIV : HOLD_PERIODS;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    typedef enum logic [2:0] {
        MANUAL    = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HI   = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LO   = 3'd4
    } state_t;

    logic [DIV_W-1:0]  div_q;
    logic              strobe;
    logic [1:0]        btn_raw;
    logic [1:0]        s1_q;
    logic [1:0]        s2_q;
    logic [1:0]        pulse;
    logic              inc_pulse;
    logic              dec_pulse;

    state_t            state_q;
    logic [DUTY_W-1:0] duty_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              inc_pend_q;
    logic              dec_pend_q;
    logic              busy_q;

    assign strobe = (div_q == DIV_W'(DEB_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)      div_q <= '0;
        else if (strobe) div_q <= '0;
        else             div_q <= div_q + 1'b1;
    end

    assign btn_raw = {btn_dec, btn_inc};

    // Buttons are sampled slowly so contact bounce settles between samples.
    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_q[gi] <= 1'b0;
                s2_q[gi] <= 1'b0;
            end else if (strobe) begin
                s1_q[gi] <= btn_raw[gi];
                s2_q[gi] <= s1_q[gi];
            end
        end
        assign pulse[gi] = s1_q[gi] & ~s2_q[gi] & strobe;
    end

    assign inc_pulse = pulse[0];
    assign dec_pulse = pulse[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= MANUAL;
            duty_q     <= DUTY_W'(DUTY_INIT);
            cnt_q      <= '0;
            inc_pend_q <= 1'b0;
            dec_pend_q <= 1'b0;
            busy_q     <= 1'b0;
        end else if (state_q == MANUAL) begin
            cnt_q <= '0;
            if (ramp_start && !ramp_stop) begin
                state_q    <= RAMP_UP;
                busy_q     <= 1'b1;
                inc_pend_q <= 1'b0;
                dec_pend_q <= 1'b0;
            end else begin
                if (period_end) begin
                    if (inc_pend_q && !dec_pend_q && duty_q != DUTY_W'(DUTY_MAX))
                        duty_q <= duty_q + 1'b1;
                    else if (dec_pend_q && !inc_pend_q && duty_q != '0)
                        duty_q <= duty_q - 1'b1;
                end
                // A pulse coinciding with period_end survives to the next boundary.
                inc_pend_q <= (inc_pend_q & ~period_end) | inc_pulse;
                dec_pend_q <= (dec_pend_q & ~period_end) | dec_pulse;
            end
        end else begin
            inc_pend_q <= 1'b0;
            dec_pend_q <= 1'b0;
            if (ramp_stop) begin
                state_q <= MANUAL;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
            end else if (period_end) begin
                case (state_q)
                    RAMP_UP: begin
                        if (cnt_q == CNT_W'(RAMP_DIV - 1)) begin
                            cnt_q <= '0;
                            if (duty_q < DUTY_W'(DUTY_MAX)) duty_q <= duty_q + 1'b1;
                            if (duty_q >= DUTY_W'(DUTY_MAX - 1)) state_q <= HOLD_HI;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    HOLD_HI: begin
                        if (cnt_q == CNT_W'(HOLD_PERIODS - 1)) begin
                            cnt_q   <= '0;
                            state_q <= RAMP_DOWN;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    RAMP_DOWN: begin
                        if (cnt_q == CNT_W'(RAMP_DIV - 1)) begin
                            cnt_q <= '0;
                            if (duty_q != '0) duty_q <= duty_q - 1'b1;
                            if (duty_q <= DUTY_W'(1)) state_q <= HOLD_LO;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    HOLD_LO: begin
                        if (cnt_q == CNT_W'(HOLD_PERIODS - 1)) begin
                            cnt_q   <= '0;
                            state_q <= RAMP_UP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: cnt_q <= '0;
                endcase
            end
        end
    end

    assign duty_out = duty_q;
    assign busy     = busy_q;
    assign at_max   = (duty_q == DUTY_W'(DUTY_MAX));
    assign at_min   = (duty_q == '0);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl: table of button presses plus hand-written
// sequences for the period_end boundary, the ramp sequencer, stop and reset.
module tb_pwm_duty_ctrl;
    logic       clk;
    logic       rst_n;
    logic       btn_inc;
    logic       btn_dec;
    logic       period_end;
    logic       ramp_start;
    logic       ramp_stop;
    logic [3:0] duty_out;
    logic       busy;
    logic       at_max;
    logic       at_min;

    logic pe_en;
    logic pe_gen;
    logic pe_manual;
    int   pe_cnt;
    int   pe_edges;
    int   checks;
    int   errors;

    typedef struct {
        bit         inc;
        bit         dec;
        logic [3:0] duty;
        bit         amax;
        bit         amin;
    } vec_t;

    vec_t vecs[22];

    pwm_duty_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .period_end (period_end),
        .ramp_start (ramp_start),
        .ramp_stop  (ramp_stop),
        .duty_out   (duty_out),
        .busy       (busy),
        .at_max     (at_max),
        .at_min     (at_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign period_end = pe_en ? pe_gen : pe_manual;

    // Free-running PWM period model: one pulse every 10 clocks.
    initial begin
        pe_cnt = 0;
        pe_gen = 1'b0;
        forever begin
            @(negedge clk);
            pe_cnt = (pe_cnt == 9) ? 0 : pe_cnt + 1;
            pe_gen = (pe_cnt == 9);
        end
    end

    // Any duty change must land on an edge with period_end high (or reset).
    initial begin
        logic [3:0] dprev;
        logic       pe_s;
        logic       rs;
        pe_edges = 0;
        forever begin
            @(negedge clk);
            dprev = duty_out;
            @(posedge clk);
            pe_s = period_end;
            rs   = rst_n;
            if (pe_s && rs) pe_edges++;
            #1;
            if (duty_out != dprev) begin
                checks++;
                if (!pe_s && rs) begin
                    errors++;
                    $display("FAIL duty_change_off_boundary: got %0d -> %0d with period_end=0", dprev, duty_out);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input bit inc, input bit dec);
        @(negedge clk);
        btn_inc = inc;
        btn_dec = dec;
        repeat (10) @(negedge clk);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
    endtask

    task automatic wait_pe(input int target, input string name);
        int n;
        n = 0;
        while (pe_edges < target && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (pe_edges < target) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout at period %0d expected period %0d", name, pe_edges, target);
        end
    endtask

    task automatic start_ramp(output int base);
        wait_pe(pe_edges + 1, "ramp_align");
        @(negedge clk);
        ramp_start = 1'b1;
        @(negedge clk);
        ramp_start = 1'b0;
        base = pe_edges;
    endtask

    initial begin
        int  base;
        bit  found;

        vecs[0]  = '{1, 0, 4'd6,  0, 0};
        vecs[1]  = '{1, 0, 4'd7,  0, 0};
        vecs[2]  = '{1, 0, 4'd8,  0, 0};
        vecs[3]  = '{1, 0, 4'd9,  0, 0};
        vecs[4]  = '{1, 0, 4'd10, 1, 0};
        vecs[5]  = '{1, 0, 4'd10, 1, 0};
        vecs[6]  = '{0, 1, 4'd9,  0, 0};
        vecs[7]  = '{0, 1, 4'd8,  0, 0};
        vecs[8]  = '{0, 1, 4'd7,  0, 0};
        vecs[9]  = '{0, 1, 4'd6,  0, 0};
        vecs[10] = '{0, 1, 4'd5,  0, 0};
        vecs[11] = '{0, 1, 4'd4,  0, 0};
        vecs[12] = '{0, 1, 4'd3,  0, 0};
        vecs[13] = '{0, 1, 4'd2,  0, 0};
        vecs[14] = '{0, 1, 4'd1,  0, 0};
        vecs[15] = '{0, 1, 4'd0,  0, 1};
        vecs[16] = '{0, 1, 4'd0,  0, 1};
        vecs[17] = '{1, 1, 4'd0,  0, 1};
        vecs[18] = '{1, 0, 4'd1,  0, 0};
        vecs[19] = '{1, 1, 4'd1,  0, 0};
        vecs[20] = '{0, 1, 4'd0,  0, 1};
        vecs[21] = '{1, 0, 4'd1,  0, 0};

        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        btn_inc    = 1'b0;
        btn_dec    = 1'b0;
        ramp_start = 1'b0;
        ramp_stop  = 1'b0;
        pe_en      = 1'b1;
        pe_manual  = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_duty", duty_out, 5);
        check("reset_busy", busy, 0);
        check("reset_at_min", at_min, 0);
        check("reset_at_max", at_max, 0);
        repeat (50) @(negedge clk);
        check("idle_duty", duty_out, 5);
        $display("reset: duty=%0d busy=%0d", duty_out, busy);

        // Manual presses from the table
        for (int i = 0; i < 22; i++) begin
            press(vecs[i].inc, vecs[i].dec);
            repeat (30) @(negedge clk);
            $display("vec %0d: inc=%0d dec=%0d duty=%0d exp=%0d", i, vecs[i].inc, vecs[i].dec, duty_out, vecs[i].duty);
            check($sformatf("vec%0d_duty", i), duty_out, vecs[i].duty);
            check($sformatf("vec%0d_at_max", i), at_max, vecs[i].amax);
            check($sformatf("vec%0d_at_min", i), at_min, vecs[i].amin);
        end

        // Edge pulse coinciding with period_end
        pe_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        btn_inc = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (dut.inc_pulse) begin
                found = 1;
                pe_manual = 1'b1;
            end
        end
        check("boundary_pulse_seen", found, 1);
        @(posedge clk);
        #1;
        check("boundary_same_edge", duty_out, 5);
        @(negedge clk);
        pe_manual = 1'b0;
        btn_inc = 1'b0;
        repeat (5) @(negedge clk);
        pe_manual = 1'b1;
        @(posedge clk);
        #1;
        check("boundary_next_edge", duty_out, 6);
        @(negedge clk);
        pe_manual = 1'b0;
        pe_en = 1'b1;
        $display("boundary: duty=%0d", duty_out);

        // Ramp from 5 with buttons pressed early on
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start_ramp(base);
        check("ramp_busy", busy, 1);
        press(1, 0);
        press(0, 1);
        wait_pe(base + 3, "ramp_p3");
        check("ramp_p3_duty", duty_out, 5);
        wait_pe(base + 4, "ramp_p4");
        check("ramp_p4_duty", duty_out, 6);
        wait_pe(base + 20, "ramp_p20");
        check("ramp_p20_duty", duty_out, 10);
        check("ramp_p20_at_max", at_max, 1);
        wait_pe(base + 22, "ramp_p22");
        check("ramp_p22_hold", duty_out, 10);
        wait_pe(base + 26, "ramp_p26");
        check("ramp_p26_duty", duty_out, 9);
        wait_pe(base + 34, "ramp_p34");
        check("ramp_p34_duty", duty_out, 7);
        wait_pe(base + 62, "ramp_p62");
        check("ramp_p62_duty", duty_out, 0);
        check("ramp_p62_at_min", at_min, 1);
        wait_pe(base + 64, "ramp_p64");
        check("ramp_p64_hold", duty_out, 0);
        wait_pe(base + 68, "ramp_p68");
        check("ramp_p68_duty", duty_out, 1);
        check("ramp_p68_busy", busy, 1);
        $display("ramp: duty=%0d busy=%0d", duty_out, busy);

        // Reset mid-ramp
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midramp_reset_duty", duty_out, 5);
        check("midramp_reset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stop in RAMP_DOWN at 7
        start_ramp(base);
        wait_pe(base + 34, "stop_p34");
        check("stop_p34_duty", duty_out, 7);
        @(negedge clk);
        ramp_stop = 1'b1;
        @(posedge clk);
        #1;
        ramp_stop = 1'b0;
        check("stop_duty", duty_out, 7);
        check("stop_busy", busy, 0);
        repeat (30) @(negedge clk);
        check("stop_settled_duty", duty_out, 7);
        $display("stop: duty=%0d busy=%0d", duty_out, busy);

        // Simultaneous start and stop stays in MANUAL
        @(negedge clk);
        ramp_start = 1'b1;
        ramp_stop  = 1'b1;
        @(posedge clk);
        #1;
        ramp_start = 1'b0;
        ramp_stop  = 1'b0;
        check("startstop_busy", busy, 0);
        repeat (50) @(negedge clk);
        check("startstop_duty", duty_out, 7);
        check("startstop_busy_late", busy, 0);
        $display("start+stop: duty=%0d busy=%0d", duty_out, busy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
